// File: rtl/stepper_phase_sequencer_pkg.sv
// Shared state encoding, phase-to-polarity table and small helpers for the
// two-coil stepper phase sequencer.
package stepper_phase_sequencer_pkg;

  localparam int StepW = 16;

  typedef logic [1:0] seqState_t;

  localparam seqState_t StIdle  = 2'd0;
  localparam seqState_t StDead  = 2'd1;
  localparam seqState_t StDwell = 2'd2;

  // Two bits per phase, {A, B}, 1 = plus polarity; phase 0 sits in the low bits.
  // phase 0 = A+ B+, phase 1 = A- B+, phase 2 = A- B-, phase 3 = A+ B-.
  localparam logic [7:0] PhasePolarity = 8'b10_00_01_11;

  function automatic logic [1:0] phasePol(input logic [1:0] ph);
    return PhasePolarity[{ph, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] nextPhase(input logic [1:0] ph, input logic dir);
    return dir ? ph + 2'd1 : ph - 2'd1;
  endfunction

endpackage

// File: rtl/stepper_phase_sequencer_if.sv
// Move-command handshake between a motion controller and the phase sequencer.
interface stepper_phase_sequencer_if;
  import stepper_phase_sequencer_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [StepW-1:0] cmd_steps;
  logic [StepW-1:0] cmd_period;
  logic             cmd_hold;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_coil_bridge.sv
// One H-bridge coil: maps {enable, polarity} to registered high/low-side gate
// drives so that a leg's high and low switch can never be on together.
module stepper_coil_bridge (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic polarity,
  output logic plus,
  output logic minus,
  output logic plusPrime,
  output logic minusPrime
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plus       <= 1'b0;
      minus      <= 1'b0;
      plusPrime  <= 1'b0;
      minusPrime <= 1'b0;
    end else begin
      plus       <= enable &  polarity;
      minusPrime <= enable &  polarity;
      minus      <= enable & ~polarity;
      plusPrime  <= enable & ~polarity;
    end
  end

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Full-step stepper sequencer: accepts move commands, steps the phase with a
// dead time on the coil that flips polarity, then dwells with both coils on.
module stepper_phase_sequencer
  import stepper_phase_sequencer_pkg::*;
#(
  parameter int DEAD_CYCLES  = 8,
  parameter bit HOLD_DEFAULT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  stepper_phase_sequencer_if.slave cmd,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [StepW-1:0]         steps_left,
  output logic [1:0]               phase,
  output logic                     MotorDriveAPlus,
  output logic                     MotorDriveAMinus,
  output logic                     MotorDriveBPlus,
  output logic                     MotorDriveBMinus,
  output logic                     MotorDriveAPlusPrime,
  output logic                     MotorDriveAMinusPrime,
  output logic                     MotorDriveBPlusPrime,
  output logic                     MotorDriveBMinusPrime
);

  localparam logic [7:0] DeadLoad = 8'(DEAD_CYCLES - 1);

  seqState_t        stateQ, stateN;
  logic [1:0]       phaseQ, phaseN;
  logic [StepW-1:0] stepsQ, stepsN;
  logic             holdQ, holdN;
  logic             doneQ, doneN;
  logic             abortedQ, abortedN;
  logic             armAQ, armAN, armBQ, armBN;
  logic             enAQ, enAN, enBQ, enBN;
  logic             dirQ, dirN;
  logic [StepW-1:0] periodQ, periodN;
  logic [StepW-1:0] dwellQ, dwellN;
  logic [7:0]       deadQ, deadN;

  logic             cmdReady;
  logic             accept;
  logic             stepStart;
  logic             changeA;
  logic [1:0]       stepPhase;
  logic [1:0]       polNow;
  logic [1:0]       polStep;
  logic [1:0]       polOut;

  // Abort outranks a simultaneous request, so ready drops while it is high.
  assign cmdReady      = (stateQ == StIdle) && !abort;
  assign cmd.cmd_ready = cmdReady;
  assign accept        = cmd.cmd_valid && cmdReady;

  assign stepPhase = nextPhase(phaseQ, (stateQ == StIdle) ? cmd.cmd_dir : dirQ);
  assign polNow    = phasePol(phaseQ);
  assign polStep   = phasePol(stepPhase);
  assign changeA   = polNow[1] != polStep[1];

  always_comb begin
    stateN    = stateQ;
    phaseN    = phaseQ;
    stepsN    = stepsQ;
    holdN     = holdQ;
    doneN     = 1'b0;
    abortedN  = abortedQ;
    armAN     = armAQ;
    armBN     = armBQ;
    enAN      = enAQ;
    enBN      = enBQ;
    dirN      = dirQ;
    periodN   = periodQ;
    dwellN    = dwellQ;
    deadN     = deadQ;
    stepStart = 1'b0;

    case (stateQ)
      StIdle: begin
        if (accept) begin
          abortedN = 1'b0;
          holdN    = cmd.cmd_hold;
          if (cmd.cmd_steps == '0) begin
            doneN = 1'b1;
          end else begin
            stateN    = StDead;
            phaseN    = stepPhase;
            stepsN    = cmd.cmd_steps;
            dirN      = cmd.cmd_dir;
            periodN   = (cmd.cmd_period == '0) ? StepW'(1) : cmd.cmd_period;
            deadN     = DeadLoad;
            stepStart = 1'b1;
          end
        end
      end

      StDead: begin
        if (abort) begin
          stateN   = StIdle;
          doneN    = 1'b1;
          abortedN = 1'b1;
        end else if (deadQ == '0) begin
          stateN = StDwell;
          dwellN = periodQ - StepW'(1);
        end else begin
          deadN = deadQ - 8'd1;
        end
      end

      StDwell: begin
        if (abort) begin
          stateN   = StIdle;
          doneN    = 1'b1;
          abortedN = 1'b1;
        end else if (dwellQ == '0) begin
          stepsN = stepsQ - StepW'(1);
          if (stepsQ == StepW'(1)) begin
            stateN = StIdle;
            doneN  = 1'b1;
          end else begin
            stateN    = StDead;
            phaseN    = stepPhase;
            deadN     = DeadLoad;
            stepStart = 1'b1;
          end
        end else begin
          dwellN = dwellQ - StepW'(1);
        end
      end

      default: stateN = StIdle;
    endcase

    // An armed coil has been driven at its present polarity since its last
    // dead time, so it may be held on while idle without another dead time.
    if (stateN == StIdle) begin
      enAN = holdN & armAN;
      enBN = holdN & armBN;
    end else if (stateN == StDwell) begin
      enAN  = 1'b1;
      enBN  = 1'b1;
      armAN = 1'b1;
      armBN = 1'b1;
    end else if (stepStart) begin
      if (changeA) begin
        enAN  = 1'b0;
        armAN = 1'b0;
      end else begin
        enBN  = 1'b0;
        armBN = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      phaseQ   <= 2'd0;
      stepsQ   <= '0;
      holdQ    <= HOLD_DEFAULT;
      doneQ    <= 1'b0;
      abortedQ <= 1'b0;
      armAQ    <= 1'b0;
      armBQ    <= 1'b0;
      enAQ     <= 1'b0;
      enBQ     <= 1'b0;
    end else begin
      stateQ   <= stateN;
      phaseQ   <= phaseN;
      stepsQ   <= stepsN;
      holdQ    <= holdN;
      doneQ    <= doneN;
      abortedQ <= abortedN;
      armAQ    <= armAN;
      armBQ    <= armBN;
      enAQ     <= enAN;
      enBQ     <= enBN;
    end
  end

  // Move parameters and counters are always loaded before they are read.
  always_ff @(posedge clk) begin
    dirQ    <= dirN;
    periodQ <= periodN;
    dwellQ  <= dwellN;
    deadQ   <= deadN;
  end

  assign busy       = stateQ != StIdle;
  assign done       = doneQ;
  assign aborted    = abortedQ;
  assign steps_left = stepsQ;
  assign phase      = phaseQ;

  // Bridges register next-cycle enables so the drives line up with the state.
  assign polOut = phasePol(phaseN);

  stepper_coil_bridge coilA (
    .clk        (clk),
    .rst        (rst),
    .enable     (enAN),
    .polarity   (polOut[1]),
    .plus       (MotorDriveAPlus),
    .minus      (MotorDriveAMinus),
    .plusPrime  (MotorDriveAPlusPrime),
    .minusPrime (MotorDriveAMinusPrime)
  );

  stepper_coil_bridge coilB (
    .clk        (clk),
    .rst        (rst),
    .enable     (enBN),
    .polarity   (polOut[0]),
    .plus       (MotorDriveBPlus),
    .minus      (MotorDriveBMinus),
    .plusPrime  (MotorDriveBPlusPrime),
    .minusPrime (MotorDriveBMinusPrime)
  );

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Bench for stepper_phase_sequencer: directed moves with literal expectations
// plus randomized commands/aborts checked every cycle against a timeline model.
module tb_stepper_phase_sequencer;
  import stepper_phase_sequencer_pkg::*;

  localparam int DEAD     = 8;
  localparam bit HOLD_DEF = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy, done, aborted;
  logic [15:0] steps_left;
  logic [1:0]  phase;
  logic aP, aM, aPP, aMP, bP, bM, bPP, bMP;
  logic [7:0] drv;

  always #5 clk = ~clk;

  stepper_phase_sequencer_if cmdIf ();

  stepper_phase_sequencer #(.DEAD_CYCLES(DEAD), .HOLD_DEFAULT(HOLD_DEF)) dut (
    .clk(clk), .rst(rst), .cmd(cmdIf.slave), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left), .phase(phase),
    .MotorDriveAPlus(aP), .MotorDriveAMinus(aM), .MotorDriveBPlus(bP), .MotorDriveBMinus(bM),
    .MotorDriveAPlusPrime(aPP), .MotorDriveAMinusPrime(aMP),
    .MotorDriveBPlusPrime(bPP), .MotorDriveBMinusPrime(bMP)
  );

  assign drv = {aP, aM, aPP, aMP, bP, bM, bPP, bMP};

  int nVec = 0;
  int nMis = 0;

  // Model: a move is a timeline of equal-length steps; t counts cycles since accept.
  bit mIdle, mHold, mDir, mDone, mAborted, mAcc, prevDone;
  bit mArm [2];
  bit mEn  [2];
  int mPhase, mPer, mLeft, mT;

  function automatic bit coilPlus(input int ph, input int c);
    if (c == 0) return (ph == 0) || (ph == 3);
    return ph < 2;
  endfunction

  function automatic logic [7:0] expDrv();
    logic [3:0] nib [2];
    for (int c = 0; c < 2; c++)
      nib[c] = !mEn[c] ? 4'b0000 : (coilPlus(mPhase, c) ? 4'b1001 : 4'b0110);
    return {nib[0], nib[1]};
  endfunction

  task automatic modelReset();
    mIdle = 1; mHold = HOLD_DEF; mDone = 0; mAborted = 0; mAcc = 0; prevDone = 0;
    mPhase = 0; mLeft = 0; mT = 0; mPer = 1; mDir = 0;
    for (int c = 0; c < 2; c++) begin mArm[c] = 0; mEn[c] = 0; end
  endtask

  task automatic startStep();
    int old;
    old = mPhase;
    mPhase = (mPhase + (mDir ? 1 : 3)) % 4;
    for (int c = 0; c < 2; c++)
      if (coilPlus(old, c) != coilPlus(mPhase, c)) begin mEn[c] = 0; mArm[c] = 0; end
  endtask

  task automatic modelEdge();
    int w;
    mDone = 0;
    mAcc = mIdle && cmdIf.cmd_valid && !abort;
    if (mIdle) begin
      if (mAcc) begin
        mAborted = 0;
        mHold = cmdIf.cmd_hold;
        if (cmdIf.cmd_steps == 16'd0) mDone = 1;
        else begin
          mIdle = 0; mDir = cmdIf.cmd_dir; mT = 0;
          mPer = (cmdIf.cmd_period == 16'd0) ? 1 : int'(cmdIf.cmd_period);
          mLeft = int'(cmdIf.cmd_steps);
          startStep();
        end
      end
      if (mIdle) for (int c = 0; c < 2; c++) mEn[c] = mHold & mArm[c];
    end else if (abort) begin
      mIdle = 1; mDone = 1; mAborted = 1;
      for (int c = 0; c < 2; c++) mEn[c] = mHold & mArm[c];
    end else begin
      mT++;
      w = mT % (DEAD + mPer);
      if (w == 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mIdle = 1; mDone = 1;
          for (int c = 0; c < 2; c++) mEn[c] = mHold & mArm[c];
        end else startStep();
      end else if (w >= DEAD) begin
        for (int c = 0; c < 2; c++) begin mEn[c] = 1; mArm[c] = 1; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    chk("busy", 32'(busy), 32'(!mIdle));
    chk("cmd_ready", 32'(cmdIf.cmd_ready), 32'(mIdle && !abort));
    chk("done", 32'(done), 32'(mDone));
    chk("aborted", 32'(aborted), 32'(mAborted));
    chk("steps_left", 32'(steps_left), 32'(mLeft));
    chk("phase", 32'(phase), 32'(mPhase));
    chk("drive", 32'(drv), 32'(expDrv()));
    chk("shoot_through", 32'({aP & aPP, aM & aMP, bP & bPP, bM & bMP}), 32'd0);
    chk("ready_while_busy", 32'(cmdIf.cmd_ready & busy), 32'd0);
    chk("done_width", 32'(done & prevDone & !mAcc), 32'd0);
    prevDone = done;
  endtask

  task automatic cyc();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  task automatic issue(input bit dir, input int steps, input int period, input bit hold);
    cmdIf.cmd_valid = 1; cmdIf.cmd_dir = dir; cmdIf.cmd_hold = hold;
    cmdIf.cmd_steps = 16'(steps); cmdIf.cmd_period = 16'(period);
    cyc();
    cmdIf.cmd_valid = 0;
  endtask

  initial begin
    int doneAt;
    rst = 1; abort = 0;
    cmdIf.cmd_valid = 0; cmdIf.cmd_dir = 0; cmdIf.cmd_hold = 0;
    cmdIf.cmd_steps = '0; cmdIf.cmd_period = '0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    chk("reset_drive", 32'(drv), 32'd0);
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 0;
    repeat (3) cyc();
    chk("hold_no_energize_from_reset", 32'(drv), 32'd0);

    // Forward move: 3 steps, period 10, hold 0.
    issue(1, 3, 10, 0);
    chk("fwd_phase_e0", 32'(phase), 32'd1);
    chk("fwd_drive_e0", 32'(drv), 32'd0);
    doneAt = -1;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (done === 1'b1 && doneAt < 0) doneAt = k;
      if (k == 8)  chk("fwd_drive_dwell1", 32'(drv), 32'h69);
      if (k == 18) begin
        chk("fwd_phase_e18", 32'(phase), 32'd2);
        chk("fwd_drive_e18", 32'(drv), 32'h60);
      end
      if (k == 36) begin
        chk("fwd_phase_e36", 32'(phase), 32'd3);
        chk("fwd_drive_e36", 32'(drv), 32'h06);
      end
    end
    chk("fwd_done_cycle", 32'(doneAt), 32'd54);
    chk("fwd_drive_after", 32'(drv), 32'd0);
    chk("fwd_model_phase", 32'(mPhase), 32'd3);

    // One step forward to phase 0 with hold, then reverse across the wrap.
    issue(1, 1, 2, 1);
    repeat (12) cyc();
    chk("hold_phase0_drive", 32'(drv), 32'h99);
    issue(0, 2, 4, 1);
    chk("rev_phase_e0", 32'(phase), 32'd3);
    chk("rev_drive_e0", 32'(drv), 32'h90);
    doneAt = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (done === 1'b1 && doneAt < 0) doneAt = k;
      if (k == 12) begin
        chk("rev_phase_e12", 32'(phase), 32'd2);
        chk("rev_drive_e12", 32'(drv), 32'h06);
      end
      if (k == 19) chk("rev_a_dead_e19", 32'(drv[7:4]), 32'd0);
      if (k == 20) chk("rev_a_on_e20", 32'(drv), 32'h66);
    end
    chk("rev_done_cycle", 32'(doneAt), 32'd24);
    chk("rev_hold_drive", 32'(drv), 32'h66);
    chk("rev_model_phase", 32'(mPhase), 32'd2);

    // Zero steps, then zero period.
    issue(1, 0, 5, 1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_phase", 32'(phase), 32'd2);
    chk("zero_busy", 32'(busy), 32'd0);
    doneAt = -1;
    issue(1, 2, 0, 1);
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (done === 1'b1 && doneAt < 0) doneAt = k;
    end
    chk("per0_done_cycle", 32'(doneAt), 32'd18);
    chk("per0_phase", 32'(phase), 32'd0);
    chk("per0_drive", 32'(drv), 32'h99);

    // Abort in dead time of step 2 of 5.
    issue(1, 5, 3, 1);
    repeat (13) cyc();
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_steps_left", 32'(steps_left), 32'd4);
    chk("abort_phase", 32'(phase), 32'd2);
    chk("abort_drive", 32'(drv), 32'h60);
    chk("abort_model_left", 32'(mLeft), 32'd4);
    repeat (3) cyc();
    issue(1, 0, 1, 1);
    chk("abort_cleared", 32'(aborted), 32'd0);
    chk("abort_b_stays_off", 32'(drv), 32'h60);

    // Asynchronous reset during dwell.
    issue(0, 2, 6, 1);
    repeat (10) cyc();
    chk("pre_reset_dwell_drive", 32'(drv), 32'h69);
    #2 rst = 1;
    #1;
    chk("async_reset_drive", 32'(drv), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_phase", 32'(phase), 32'd0);
    chk("async_reset_steps", 32'(steps_left), 32'd0);
    @(negedge clk);
    modelReset();
    compareAll();
    rst = 0;

    // Randomized commands and aborts.
    for (int n = 0; n < 3000; n++) begin
      cmdIf.cmd_valid  = ($urandom_range(0, 99) < 40);
      cmdIf.cmd_dir    = 1'($urandom_range(0, 1));
      cmdIf.cmd_hold   = 1'($urandom_range(0, 1));
      cmdIf.cmd_steps  = 16'($urandom_range(0, 4));
      cmdIf.cmd_period = 16'($urandom_range(0, 5));
      abort            = ($urandom_range(0, 99) < 3);
      cyc();
    end
    cmdIf.cmd_valid = 0;
    abort = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
